// File: rtl/ux607_tl_pkg.sv
// Shared constants for the byte-wide TileLink-UL responder:
// A/D opcodes, FSM state encoding and beat-counter sizing.
package ux607_tl_pkg;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;

  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PUT    = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;

  // Size fields go up to 7, so a transfer can have up to 128 beats.
  localparam int BEAT_W = 8;

  // Index of the final beat of a 2^size-beat transfer.
  function automatic logic [BEAT_W-1:0] last_beat(input logic [2:0] size);
    return BEAT_W'(((BEAT_W+1)'(1) << size) - (BEAT_W+1)'(1));
  endfunction

endpackage

// File: rtl/ux607_tl_byte_responder.sv
// Byte-wide TileLink-UL slave: turns A beats into single-outstanding register
// accesses, expands multi-beat Gets into per-byte reads and collapses
// multi-beat Puts into one AccessAck. Illegal transfers never touch the bus.
module ux607_tl_byte_responder
  import ux607_tl_pkg::*;
#(
  parameter int   MAX_SIZE = 2,
  parameter logic SINK_ID  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_a_valid,
  output logic        io_a_ready,
  input  logic [2:0]  io_a_bits_opcode,
  input  logic [2:0]  io_a_bits_param,
  input  logic [2:0]  io_a_bits_size,
  input  logic [1:0]  io_a_bits_source,
  input  logic [29:0] io_a_bits_address,
  input  logic        io_a_bits_mask,
  input  logic [7:0]  io_a_bits_data,
  input  logic        io_d_ready,
  output logic        io_d_valid,
  output logic [2:0]  io_d_bits_opcode,
  output logic [1:0]  io_d_bits_param,
  output logic [2:0]  io_d_bits_size,
  output logic [1:0]  io_d_bits_source,
  output logic        io_d_bits_sink,
  output logic [7:0]  io_d_bits_data,
  output logic        io_d_bits_error,
  output logic        io_reg_req,
  output logic        io_reg_we,
  output logic [29:0] io_reg_addr,
  output logic [7:0]  io_reg_wdata,
  input  logic        io_reg_rvalid,
  input  logic [7:0]  io_reg_rdata,
  input  logic        io_reg_err
);

  logic [2:0]        state, state_n;
  logic              rdy_q, get_q, ill_q, err_q, d_err_q;
  logic [2:0]        size_q;
  logic [1:0]        src_q;
  logic [29:0]       addr_q;
  logic [BEAT_W-1:0] beat_q;
  logic [7:0]        wdata_q, d_data_q;

  logic        a_fire, d_fire, a_is_get, a_legal, a_size0, beat_last;
  logic [29:0] a_align_mask;
  logic        unused_param;

  assign unused_param = ^io_a_bits_param;

  assign a_fire       = io_a_valid & rdy_q;
  assign d_fire       = (state == ST_RESP) & io_d_ready;
  assign a_is_get     = io_a_bits_opcode == A_GET;
  assign a_size0      = io_a_bits_size == 3'd0;
  assign a_align_mask = (30'd1 << io_a_bits_size) - 30'd1;
  assign a_legal      = (io_a_bits_opcode == A_PUT_FULL || io_a_bits_opcode == A_PUT_PARTIAL || a_is_get)
                      && (int'({29'd0, io_a_bits_size}) <= MAX_SIZE)
                      && ((io_a_bits_address & a_align_mask) == 30'd0);
  assign beat_last    = beat_q == last_beat(size_q);

  // Next-state selection; beat_q always indexes the beat being worked on.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:
        if (a_fire) begin
          if (a_is_get)             state_n = a_legal ? ST_ACCESS : ST_RESP;
          else if (!a_legal)        state_n = a_size0 ? ST_RESP : ST_DRAIN;
          else if (io_a_bits_mask)  state_n = ST_ACCESS;
          else                      state_n = a_size0 ? ST_RESP : ST_PUT;
        end
      ST_PUT:
        if (a_fire) state_n = io_a_bits_mask ? ST_ACCESS : (beat_last ? ST_RESP : ST_PUT);
      ST_DRAIN:
        if (a_fire && beat_last) state_n = ST_RESP;
      ST_ACCESS:
        state_n = ST_WAIT;
      ST_WAIT:
        if (io_reg_rvalid) state_n = (get_q || beat_last) ? ST_RESP : ST_PUT;
      ST_RESP:
        if (d_fire) state_n = (get_q && !beat_last) ? (ill_q ? ST_RESP : ST_ACCESS) : ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  // Transfer capture, beat counting, sticky error and registered D payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      rdy_q    <= 1'b0;
      get_q    <= 1'b0;
      ill_q    <= 1'b0;
      err_q    <= 1'b0;
      d_err_q  <= 1'b0;
      size_q   <= '0;
      src_q    <= '0;
      addr_q   <= '0;
      beat_q   <= '0;
      wdata_q  <= '0;
      d_data_q <= '0;
    end else begin
      state <= state_n;
      // Registered ready: no A accept in the cycle a D beat retires to IDLE.
      rdy_q <= (state_n == ST_IDLE) || (state_n == ST_PUT) || (state_n == ST_DRAIN);
      case (state)
        ST_IDLE:
          if (a_fire) begin
            get_q    <= a_is_get;
            ill_q    <= !a_legal;
            size_q   <= io_a_bits_size;
            src_q    <= io_a_bits_source;
            addr_q   <= io_a_bits_address;
            wdata_q  <= io_a_bits_data;
            d_data_q <= '0;
            err_q    <= !a_legal;
            d_err_q  <= !a_legal;
            // Put beats that complete without an access move straight to beat 1.
            beat_q   <= (!a_is_get && !a_size0 && (!a_legal || !io_a_bits_mask))
                        ? BEAT_W'(1) : '0;
          end
        ST_PUT:
          if (a_fire) begin
            wdata_q <= io_a_bits_data;
            if (!io_a_bits_mask) begin
              if (beat_last) d_err_q <= err_q;
              else           beat_q  <= beat_q + BEAT_W'(1);
            end
          end
        ST_DRAIN:
          if (a_fire && !beat_last) beat_q <= beat_q + BEAT_W'(1);
        ST_WAIT:
          if (io_reg_rvalid) begin
            if (get_q) begin
              d_data_q <= io_reg_rdata;
              d_err_q  <= io_reg_err;
            end else begin
              err_q <= err_q | io_reg_err;
              if (beat_last) d_err_q <= err_q | io_reg_err;
              else           beat_q  <= beat_q + BEAT_W'(1);
            end
          end
        ST_RESP:
          if (d_fire && get_q && !beat_last) beat_q <= beat_q + BEAT_W'(1);
        default: ;
      endcase
    end
  end

  assign io_a_ready       = rdy_q;
  assign io_d_valid       = state == ST_RESP;
  assign io_d_bits_opcode = get_q ? D_ACK_DATA : D_ACK;
  assign io_d_bits_param  = 2'd0;
  assign io_d_bits_size   = size_q;
  assign io_d_bits_source = src_q;
  assign io_d_bits_sink   = SINK_ID;
  assign io_d_bits_data   = d_data_q;
  assign io_d_bits_error  = d_err_q;

  assign io_reg_req   = state == ST_ACCESS;
  assign io_reg_we    = (state == ST_ACCESS) & !get_q;
  assign io_reg_addr  = (state == ST_ACCESS) ? addr_q + {{(30-BEAT_W){1'b0}}, beat_q} : '0;
  assign io_reg_wdata = ((state == ST_ACCESS) & !get_q) ? wdata_q : '0;

endmodule

// File: tb/tb_ux607_tl_byte_responder.sv
// Directed bench: expected D beats and register accesses are queued as each
// stimulus step is issued and popped as the responder produces them.
module tb_ux607_tl_byte_responder;

  localparam logic SINK = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_a_valid, io_a_ready;
  logic [2:0]  io_a_bits_opcode, io_a_bits_param, io_a_bits_size;
  logic [1:0]  io_a_bits_source;
  logic [29:0] io_a_bits_address;
  logic        io_a_bits_mask;
  logic [7:0]  io_a_bits_data;
  logic        io_d_ready, io_d_valid;
  logic [2:0]  io_d_bits_opcode, io_d_bits_size;
  logic [1:0]  io_d_bits_param, io_d_bits_source;
  logic        io_d_bits_sink, io_d_bits_error;
  logic [7:0]  io_d_bits_data;
  logic        io_reg_req, io_reg_we, io_reg_rvalid, io_reg_err;
  logic [29:0] io_reg_addr;
  logic [7:0]  io_reg_wdata, io_reg_rdata;

  always #5 clock = ~clock;

  ux607_tl_byte_responder #(.MAX_SIZE(2), .SINK_ID(SINK)) dut (
    .clock(clock), .reset(reset),
    .io_a_valid(io_a_valid), .io_a_ready(io_a_ready),
    .io_a_bits_opcode(io_a_bits_opcode), .io_a_bits_param(io_a_bits_param),
    .io_a_bits_size(io_a_bits_size), .io_a_bits_source(io_a_bits_source),
    .io_a_bits_address(io_a_bits_address), .io_a_bits_mask(io_a_bits_mask),
    .io_a_bits_data(io_a_bits_data),
    .io_d_ready(io_d_ready), .io_d_valid(io_d_valid),
    .io_d_bits_opcode(io_d_bits_opcode), .io_d_bits_param(io_d_bits_param),
    .io_d_bits_size(io_d_bits_size), .io_d_bits_source(io_d_bits_source),
    .io_d_bits_sink(io_d_bits_sink), .io_d_bits_data(io_d_bits_data),
    .io_d_bits_error(io_d_bits_error),
    .io_reg_req(io_reg_req), .io_reg_we(io_reg_we), .io_reg_addr(io_reg_addr),
    .io_reg_wdata(io_reg_wdata), .io_reg_rvalid(io_reg_rvalid),
    .io_reg_rdata(io_reg_rdata), .io_reg_err(io_reg_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  logic [19:0] dq[$];
  logic [38:0] rq[$];
  logic [7:0]  mem [0:255];
  logic [29:0] err_addr = '1;
  bit          rsp_off = 1'b0;
  int          rsp_lat = 1;
  int          stall_n = 0;
  int          req_cyc = -1;
  int          dv_cyc = -1;

  logic [61:0] outs;
  assign outs = {io_a_ready, io_d_valid, io_d_bits_opcode, io_d_bits_param, io_d_bits_size,
                 io_d_bits_source, io_d_bits_sink, io_d_bits_data, io_d_bits_error,
                 io_reg_req, io_reg_we, io_reg_addr, io_reg_wdata};
  logic [61:0] exp_rst;
  assign exp_rst = {2'b00, 3'd0, 2'd0, 3'd0, 2'd0, SINK, 8'd0, 1'b0, 1'b0, 1'b0, 30'd0, 8'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk_d(input logic [2:0] op, input logic [2:0] sz,
                                       input logic [1:0] src, input logic [7:0] dat, input logic er);
    return {op, 2'b00, sz, src, SINK, dat, er};
  endfunction

  // Register-bus model: checks each request, then pulses completion.
  initial begin : responder
    logic [38:0] got;
    logic [29:0] ra;
    logic        rwe;
    io_reg_rvalid = 1'b0; io_reg_rdata = '0; io_reg_err = 1'b0;
    forever begin
      @(negedge clock);
      if (io_reg_req === 1'b1) begin
        req_cyc = cyc;
        got = {io_reg_we, io_reg_addr, io_reg_wdata};
        if (rq.size() == 0) chk("reg_unexpected", 64'(rq.size()), 64'd1);
        else chk("reg_req", 64'(got), 64'(rq.pop_front()));
        ra = io_reg_addr; rwe = io_reg_we;
        if (rwe) mem[ra[7:0]] = io_reg_wdata;
        if (!rsp_off) begin
          repeat (rsp_lat) @(posedge clock);
          #1;
          io_reg_rvalid = 1'b1;
          io_reg_err    = (ra == err_addr);
          io_reg_rdata  = (rwe || ra == err_addr) ? 8'h00 : mem[ra[7:0]];
          @(posedge clock);
          #1;
          io_reg_rvalid = 1'b0; io_reg_rdata = '0; io_reg_err = 1'b0;
        end
      end
    end
  end

  // D-channel sink: stalls each beat stall_n cycles.
  initial begin : d_sink
    int scnt;
    scnt = 0;
    io_d_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (io_d_valid === 1'b1) begin
        if (scnt < stall_n) begin io_d_ready = 1'b0; scnt++; end
        else begin io_d_ready = 1'b1; scnt = 0; end
      end else io_d_ready = (stall_n == 0);
    end
  end

  // D-channel monitor: every valid cycle is checked against the queue head.
  initial begin : d_mon
    logic [19:0] got;
    logic        prev;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (io_d_valid === 1'b1 && !prev) dv_cyc = cyc;
      prev = (io_d_valid === 1'b1);
      if (io_d_valid === 1'b1) begin
        got = {io_d_bits_opcode, io_d_bits_param, io_d_bits_size, io_d_bits_source,
               io_d_bits_sink, io_d_bits_data, io_d_bits_error};
        if (dq.size() == 0) chk("d_unexpected", 64'(dq.size()), 64'd1);
        else begin
          chk("d_beat", 64'(got), 64'(dq[0]));
          if (io_d_ready) void'(dq.pop_front());
        end
      end
    end
  end

  // Drive one A beat from just after a rising edge until it is accepted.
  task automatic a_beat(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                        input logic [29:0] addr, input logic m, input logic [7:0] d, output int fc);
    logic r;
    int   n;
    io_a_valid = 1'b1; io_a_bits_opcode = op; io_a_bits_size = sz; io_a_bits_source = src;
    io_a_bits_address = addr; io_a_bits_mask = m; io_a_bits_data = d; io_a_bits_param = 3'd0;
    n = 0; fc = -1;
    forever begin
      @(negedge clock);
      r = io_a_ready; fc = cyc;
      @(posedge clock);
      if (r) break;
      n++;
      if (n > 300) begin chk("a_timeout", 64'(n), 64'd0); break; end
    end
    #1 io_a_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (dq.size() == 0 && rq.size() == 0 && io_d_valid === 1'b0 && io_a_ready === 1'b1) break;
      n++;
      if (n > 2000) begin chk(tag, 64'(n), 64'd0); break; end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin : main
    int fc;
    logic [7:0] pd [4];
    pd = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hA5;
    mem[8'h60] = 8'hC0; mem[8'h61] = 8'hC1; mem[8'h62] = 8'hC2; mem[8'h63] = 8'hC3;
    io_a_valid = 1'b0; io_a_bits_opcode = '0; io_a_bits_param = '0; io_a_bits_size = '0;
    io_a_bits_source = '0; io_a_bits_address = '0; io_a_bits_mask = 1'b0; io_a_bits_data = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", 64'(outs), 64'(exp_rst));
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("a_ready_after_reset", 64'(io_a_ready), 64'd1);
    @(posedge clock); #1;

    // Single-beat Get with 1-cycle register latency
    rq.push_back({1'b0, 30'h10, 8'h00});
    dq.push_back(mk_d(3'd1, 3'd0, 2'd1, 8'hA5, 1'b0));
    a_beat(3'd4, 3'd0, 2'd1, 30'h10, 1'b1, 8'h00, fc);
    wait_idle("t1_timeout");
    chk("t1_req_latency", 64'(req_cyc - fc), 64'd1);
    chk("t1_d_latency", 64'(dv_cyc - fc), 64'd3);

    // PutFull size 2, slower register bus
    rsp_lat = 3;
    for (int i = 0; i < 4; i++) rq.push_back({1'b1, 30'h20 + 30'(i), pd[i]});
    dq.push_back(mk_d(3'd0, 3'd2, 2'd2, 8'h00, 1'b0));
    for (int i = 0; i < 4; i++) a_beat(3'd0, 3'd2, 2'd2, 30'h20, 1'b1, pd[i], fc);
    wait_idle("t2_timeout");
    rsp_lat = 1;

    // Read the Put data back
    for (int i = 0; i < 4; i++) begin
      rq.push_back({1'b0, 30'h20 + 30'(i), 8'h00});
      dq.push_back(mk_d(3'd1, 3'd2, 2'd0, pd[i], 1'b0));
    end
    a_beat(3'd4, 3'd2, 2'd0, 30'h20, 1'b1, 8'h00, fc);
    wait_idle("t2b_timeout");

    // PutPartial size 1, masks 1 then 0
    rq.push_back({1'b1, 30'h30, 8'h77});
    dq.push_back(mk_d(3'd0, 3'd1, 2'd3, 8'h00, 1'b0));
    a_beat(3'd1, 3'd1, 2'd3, 30'h30, 1'b1, 8'h77, fc);
    a_beat(3'd1, 3'd1, 2'd3, 30'h30, 1'b0, 8'h88, fc);
    wait_idle("t3_timeout");

    // Put error on the first beat stays sticky into the AccessAck
    err_addr = 30'h50;
    rq.push_back({1'b1, 30'h50, 8'hAA});
    rq.push_back({1'b1, 30'h51, 8'hBB});
    dq.push_back(mk_d(3'd0, 3'd1, 2'd0, 8'h00, 1'b1));
    a_beat(3'd0, 3'd1, 2'd0, 30'h50, 1'b1, 8'hAA, fc);
    a_beat(3'd0, 3'd1, 2'd0, 30'h50, 1'b1, 8'hBB, fc);
    wait_idle("t3b_timeout");

    // Get size 2, error on beat 2 only, D stalled 3 cycles per beat
    err_addr = 30'h62;
    stall_n = 3;
    for (int i = 0; i < 4; i++) rq.push_back({1'b0, 30'h60 + 30'(i), 8'h00});
    dq.push_back(mk_d(3'd1, 3'd2, 2'd1, 8'hC0, 1'b0));
    dq.push_back(mk_d(3'd1, 3'd2, 2'd1, 8'hC1, 1'b0));
    dq.push_back(mk_d(3'd1, 3'd2, 2'd1, 8'h00, 1'b1));
    dq.push_back(mk_d(3'd1, 3'd2, 2'd1, 8'hC3, 1'b0));
    a_beat(3'd4, 3'd2, 2'd1, 30'h60, 1'b1, 8'h00, fc);
    wait_idle("t4_timeout");
    stall_n = 0;
    err_addr = '1;

    // Illegal opcode 2 size 1: two beats drained, one error AccessAck
    dq.push_back(mk_d(3'd0, 3'd1, 2'd2, 8'h00, 1'b1));
    a_beat(3'd2, 3'd1, 2'd2, 30'h70, 1'b1, 8'h12, fc);
    a_beat(3'd2, 3'd1, 2'd2, 30'h70, 1'b1, 8'h34, fc);
    wait_idle("t5a_timeout");

    // Get size 3 above MAX_SIZE: eight error beats
    for (int i = 0; i < 8; i++) dq.push_back(mk_d(3'd1, 3'd3, 2'd0, 8'h00, 1'b1));
    a_beat(3'd4, 3'd3, 2'd0, 30'h80, 1'b1, 8'h00, fc);
    wait_idle("t5b_timeout");

    // Misaligned Get size 1
    for (int i = 0; i < 2; i++) dq.push_back(mk_d(3'd1, 3'd1, 2'd1, 8'h00, 1'b1));
    a_beat(3'd4, 3'd1, 2'd1, 30'h91, 1'b1, 8'h00, fc);
    wait_idle("t5c_timeout");

    // Reset while waiting on the register bus
    rsp_off = 1'b1;
    rq.push_back({1'b0, 30'h10, 8'h00});
    a_beat(3'd4, 3'd0, 2'd2, 30'h10, 1'b1, 8'h00, fc);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("t6_reset_outputs", 64'(outs), 64'(exp_rst));
    @(posedge clock); #1 reset = 1'b0; rsp_off = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("t6_a_ready", 64'(io_a_ready), 64'd1);
    chk("t6_req_seen", 64'(rq.size()), 64'd0);
    @(posedge clock); #1;

    // Fresh Get after reset completes normally
    rq.push_back({1'b0, 30'h10, 8'h00});
    dq.push_back(mk_d(3'd1, 3'd0, 2'd2, 8'hA5, 1'b0));
    a_beat(3'd4, 3'd0, 2'd2, 30'h10, 1'b1, 8'h00, fc);
    wait_idle("t6b_timeout");

    chk("d_queue_empty", 64'(dq.size()), 64'd0);
    chk("reg_queue_empty", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ux607_tl_byte_responder.md
# ux607_tl_byte_responder

Byte-wide TileLink-UL responder at the slave end of the peripheral fragmentation path; it terminates A-channel beats from the request-side repeater/fragmenter and generates D-channel responses. Each legal beat becomes one access on a simple single-outstanding register bus. Multi-beat Gets are expanded here into one register read per byte, each returned as a D beat. Multi-beat Puts are collected here and answered with a single AccessAck.

## Interface
Parameters:
- MAX_SIZE, 2: largest legal lg2(bytes); larger size is an error transfer.
- SINK_ID, 0: constant value driven on io_d_bits_sink.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- io_a_valid / io_a_ready  in / out  1  A-channel handshake.
- io_a_bits_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get; others illegal.
- io_a_bits_param  in  3  ignored.
- io_a_bits_size  in  3  lg2 transfer bytes; beats = 2^size.
- io_a_bits_source  in  2  echoed on D.
- io_a_bits_address  in  30  byte address.
- io_a_bits_mask  in  1  byte-write enable.
- io_a_bits_data  in  8  write data.
- io_d_ready / io_d_valid  in / out  1  D-channel handshake.
- io_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData.
- io_d_bits_param  out  2  always 0.
- io_d_bits_size  out  3  captured size.
- io_d_bits_source  out  2  captured source.
- io_d_bits_sink  out  1  SINK_ID.
- io_d_bits_data  out  8  read data; 0 on Put responses and error beats.
- io_d_bits_error  out  1  transfer error.
- io_reg_req  out  1  one-cycle access strobe.
- io_reg_we  out  1  1=write; valid with io_reg_req.
- io_reg_addr  out  30  valid with io_reg_req.
- io_reg_wdata  out  8  valid with io_reg_req.
- io_reg_rvalid  in  1  completion pulse, earliest the cycle after io_reg_req.
- io_reg_rdata  in  8  valid with io_reg_rvalid.
- io_reg_err  in  1  valid with io_reg_rvalid.

## Operation
- FSM states: IDLE, PUT, ACCESS, WAIT, RESP, DRAIN.
- IDLE: io_a_ready=1. A fire captures opcode, size, source and address; clears beat counter (8 bits) and sticky error.
- Illegal transfer: opcode not in {0,1,4}, size>MAX_SIZE, or address[size-1:0]!=0. No register access for any beat.
  - Put: go to DRAIN, accept the remaining 2^size-1 beats, then RESP with one AccessAck, error=1.
  - Get: RESP emits 2^size AccessAckData beats, data=0, error=1.
- Legal Put beat, mask=1: go to ACCESS. io_reg_req=1, we=1, addr=base+beat, wdata=beat data.
- Legal Put beat, mask=0: no access; treated as completed.
- WAIT: hold until io_reg_rvalid; OR io_reg_err into sticky error.
  - Put beat not last: go to PUT (io_a_ready=1 for the next beat).
  - Put beat last: go to RESP with one AccessAck, error=sticky.
- Legal Get: ACCESS issues a read (we=0, addr=base+beat). WAIT latches rdata and err; RESP drives one AccessAckData beat.
  - On D fire: beat++. If beats remain, go to ACCESS; else go to IDLE.
- Get error is per-beat (that beat's io_reg_err), not sticky.
- io_a_ready=0 in ACCESS, WAIT, RESP. At most one register access outstanding.
- io_reg_rvalid outside WAIT is ignored.
- A beat opcode/size/source mismatching the captured values mid-Put is not checked.

## Timing
- Reset: state=IDLE. All outputs 0, except io_a_ready=1 from the first cycle after reset deasserts. io_d_bits_sink=SINK_ID.
- Reset mid-transfer: abandons the transfer with no D response; captured fields and counter are cleared.
- A fire in cycle N: io_reg_req in N+1; io_reg_rvalid at N+k (k≥2); io_d_valid in N+k+1.
- Single-beat Get or Put with 1-cycle register latency: A fire to D valid = 3 cycles.
- All D outputs come from registers and are stable while io_d_valid=1 and io_d_ready=0.
- D fire in IDLE-bound RESP: io_a_ready=1 in the next cycle; no same-cycle A accept.
- Address arithmetic: base + beat, 30-bit, wraps modulo 2^30. Alignment makes wrap unreachable for legal transfers.

## Structure
- Shared package ux607_tl_pkg: A/D opcode constants, FSM state encoding, beat-count width constant.
- Single flat module; no sub-module. The beat counter is inline.

## Test plan
- Get size=0, addr=0x10, reg rdata=0xA5 after 1 cycle -> req at N+1; D beat AccessAckData, data=0xA5, error=0, at N+3.
- PutFull size=2, addr=0x20, data 11,22,33,44 -> four writes at 0x20..0x23; a single AccessAck after the 4th completion.
- PutPartial size=1, masks 1,0 -> exactly one write at base; one AccessAck, error=0.
- Get size=2 with reg_err on beat 2, io_d_ready stalled 3 cycles per beat -> four D beats; only beat 2 has error=1; D fields stable during stalls.
- Illegal opcode 2 size=1; then Get size=3 with MAX_SIZE=2 -> for the opcode-2 transfer, 2 beats drained and one error AccessAck; for the Get, 8 error AccessAckData beats, data=0; no io_reg_req throughout.
- Reset asserted in WAIT -> next cycle all outputs 0; io_a_ready=1 after release; a fresh Get completes normally.
